// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Definitions shared by the SPI program loader and the downstream
// InstructionDecoder/ExecutionUnit pair.
//   - state_t           : loader FSM states (IDLE, LOAD, RUN, FINISH)
//   - FRAME_BITS        : width of one SPI instruction frame {opcode, operand}
//   - NOP_OPCODE_DEFAULT: opcode that decodes to no control line
//   - OPC_*             : opcode values understood by InstructionDecoder
// -----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int FRAME_BITS = 12;

  localparam logic [3:0] NOP_OPCODE_DEFAULT = 4'h0;

  // Opcode map shared with InstructionDecoder
  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_LOAD_A = 4'h1;
  localparam logic [3:0] OPC_LOAD_B = 4'h2;
  localparam logic [3:0] OPC_ADD    = 4'h3;
  localparam logic [3:0] OPC_SUB    = 4'h4;
  localparam logic [3:0] OPC_AND    = 4'h5;
  localparam logic [3:0] OPC_OR     = 4'h6;
  localparam logic [3:0] OPC_OUT    = 4'hF;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchroniser for one asynchronous SPI line, followed by a history
// flop that yields registered single-cycle rise/fall pulses in the clk domain.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-low reset
//   async_in in  asynchronous input line
//   rise     out one-cycle pulse after a synchronised 0->1 transition
//   fall     out one-cycle pulse after a synchronised 1->0 transition
// RESET_VAL should match the idle level of the line so leaving reset does not
// fabricate an edge (0 for sck in mode 0, 1 for cs_n).
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic rise_r;
  logic fall_r;

  // Synchroniser chain, history flop and registered edge pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
      prev_r <= RESET_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
      rise_r <= sync_r & ~prev_r;
      fall_r <= ~sync_r & prev_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/spi_program_loader.sv
// -----------------------------------------------------------------------------
// spi_program_loader
// Upstream stage of ExecutionUnit. A mode-0 SPI slave collects 12-bit
// {opcode, operand} frames into a program buffer; a rising edge on run replays
// the buffer one instruction per STEP_CYCLES clocks, then pulses start.
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   spi_sck/cs_n/mosi   SPI slave inputs (asynchronous, f_sck <= f_clk/4)
//   spi_miso            SPI slave output (echo of previous frame, see below)
//   run                 level; rising edge in IDLE starts replay
//   opcode, operand     instruction bus to ExecutionUnit (NOP/0 when idle)
//   start               one-cycle pulse after the last instruction
//   busy                high in LOAD, RUN and FINISH
//   prog_len            number of stored instructions
//   overflow            sticky: a frame arrived with the buffer full
// Configuration macro SPI_LOADER_ECHO_EN: when defined, spi_miso shifts out the
// previously completed frame during LOAD; otherwise spi_miso is tied low.
// -----------------------------------------------------------------------------
module spi_program_loader
  import loader_pkg::*;
#(
  parameter int                          ROM_ADDRESS_WIDTH = 5,
  parameter int                          INPUT_DATA_WIDTH  = 4,
  parameter int                          STEP_CYCLES       = 1,
  parameter logic [INPUT_DATA_WIDTH-1:0] NOP_OPCODE        = NOP_OPCODE_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            spi_sck,
  input  logic                            spi_cs_n,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  input  logic                            run,
  output logic [INPUT_DATA_WIDTH-1:0]     opcode,
  output logic [2*INPUT_DATA_WIDTH-1:0]   operand,
  output logic                            start,
  output logic                            busy,
  output logic [ROM_ADDRESS_WIDTH:0]      prog_len,
  output logic                            overflow
);

  localparam int AW    = ROM_ADDRESS_WIDTH;
  localparam int OW    = 2 * INPUT_DATA_WIDTH;
  localparam int FW    = INPUT_DATA_WIDTH + OW;
  localparam int DEPTH = 2 ** AW;
  localparam int BW    = $clog2(FW);
  localparam int SW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FW - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEP_CYCLES - 1);

  // Synchronised SPI events
  logic sck_rise_s;
  logic sck_fall_s;
  logic cs_rise_s;
  logic cs_fall_s;
  logic mosi_meta_r;
  logic mosi_sync_r;

  // Architectural state and next-state values
  state_t        state_r,    state_nx;
  logic          run_prev_r;
  logic [BW-1:0] bit_cnt_r,  bit_cnt_nx;
  logic [FW-2:0] shift_r,    shift_nx;
  logic [AW:0]   prog_len_r, prog_len_nx;
  logic          overflow_r, overflow_nx;
  logic [AW:0]   pc_r,       pc_nx;
  logic [SW-1:0] step_r,     step_nx;
  logic [INPUT_DATA_WIDTH-1:0] opcode_r, opcode_nx;
  logic [OW-1:0] operand_r,  operand_nx;
  logic          start_r,    start_nx;
  logic          busy_r;

  // Buffer ports
  logic [FW-1:0] mem_r [DEPTH];
  logic          wr_en_s;
  logic [FW-1:0] wr_data_s;
  logic [AW-1:0] rd_addr_s;
  logic [FW-1:0] rd_data_s;
  logic [AW:0]   pc_inc_s;
  logic          run_rise_s;
  logic          frame_end_s;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_sck),
    .rise     (sck_rise_s),
    .fall     (sck_fall_s)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_cs_n),
    .rise     (cs_rise_s),
    .fall     (cs_fall_s)
  );

  // mosi only needs to be stable around the synchronised sck rise, so no edge detect
  always_ff @(posedge clk) begin
    if (!reset) begin
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      mosi_meta_r <= spi_mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  assign run_rise_s  = run & ~run_prev_r;
  assign pc_inc_s    = pc_r + 1'b1;
  assign wr_data_s   = {shift_r, mosi_sync_r};
  assign frame_end_s = (state_r == LOAD) && !cs_rise_s && sck_rise_s && (bit_cnt_r == LAST_BIT);

  // Read address: slot 0 when launching a run, otherwise the instruction after pc
  always_comb begin
    rd_addr_s = '0;
    if (state_r == RUN) begin
      rd_addr_s = pc_inc_s[AW-1:0];
    end else begin
      rd_addr_s = '0;
    end
  end

  assign rd_data_s = mem_r[rd_addr_s];

  // Program buffer write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[prog_len_r[AW-1:0]] <= wr_data_s;
    end
  end

  // FSM next-state and next-output logic
  always_comb begin
    state_nx    = state_r;
    bit_cnt_nx  = bit_cnt_r;
    shift_nx    = shift_r;
    prog_len_nx = prog_len_r;
    overflow_nx = overflow_r;
    pc_nx       = pc_r;
    step_nx     = step_r;
    opcode_nx   = NOP_OPCODE;
    operand_nx  = '0;
    start_nx    = 1'b0;
    wr_en_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          state_nx    = LOAD;
          prog_len_nx = '0;
          overflow_nx = 1'b0;
          bit_cnt_nx  = '0;
        end else if (run_rise_s) begin
          pc_nx   = '0;
          step_nx = '0;
          if (prog_len_r == '0) begin
            state_nx = FINISH;
            start_nx = 1'b1;
          end else begin
            // Output registers load slot 0 now so it shows the next cycle
            state_nx   = RUN;
            opcode_nx  = rd_data_s[FW-1:OW];
            operand_nx = rd_data_s[OW-1:0];
          end
        end else begin
          state_nx = IDLE;
        end
      end

      LOAD: begin
        if (cs_rise_s) begin
          // Any partial frame is abandoned; bit_cnt is cleared on the next entry
          state_nx = IDLE;
        end else if (sck_rise_s) begin
          shift_nx = wr_data_s[FW-2:0];
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_nx = '0;
            if (prog_len_r == FULL) begin
              overflow_nx = 1'b1;
            end else begin
              wr_en_s     = 1'b1;
              prog_len_nx = prog_len_r + 1'b1;
            end
          end else begin
            bit_cnt_nx = bit_cnt_r + 1'b1;
          end
        end else begin
          state_nx = LOAD;
        end
      end

      RUN: begin
        if (step_r == LAST_STEP) begin
          step_nx = '0;
          if (pc_r == prog_len_r - 1'b1) begin
            state_nx = FINISH;
            start_nx = 1'b1;
          end else begin
            pc_nx      = pc_inc_s;
            opcode_nx  = rd_data_s[FW-1:OW];
            operand_nx = rd_data_s[OW-1:0];
          end
        end else begin
          step_nx    = step_r + 1'b1;
          opcode_nx  = opcode_r;
          operand_nx = operand_r;
        end
      end

      FINISH: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      run_prev_r <= 1'b0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      prog_len_r <= '0;
      overflow_r <= 1'b0;
      pc_r       <= '0;
      step_r     <= '0;
      opcode_r   <= NOP_OPCODE;
      operand_r  <= '0;
      start_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      run_prev_r <= run;
      bit_cnt_r  <= bit_cnt_nx;
      shift_r    <= shift_nx;
      prog_len_r <= prog_len_nx;
      overflow_r <= overflow_nx;
      pc_r       <= pc_nx;
      step_r     <= step_nx;
      opcode_r   <= opcode_nx;
      operand_r  <= operand_nx;
      start_r    <= start_nx;
      busy_r     <= (state_nx != IDLE);
    end
  end

  assign opcode   = opcode_r;
  assign operand  = operand_r;
  assign start    = start_r;
  assign busy     = busy_r;
  assign prog_len = prog_len_r;
  assign overflow = overflow_r;

`ifdef SPI_LOADER_ECHO_EN
  logic [FW-1:0] echo_frame_r;
  logic          miso_r;
  logic [BW-1:0] echo_idx_s;

  // bit_cnt already counts the bits received, so it points at the next bit to send
  assign echo_idx_s = LAST_BIT - bit_cnt_r;

  // Echo of the previously completed frame, advanced on sck fall
  always_ff @(posedge clk) begin
    if (!reset) begin
      echo_frame_r <= '0;
      miso_r       <= 1'b0;
    end else if ((state_r == IDLE) && cs_fall_s) begin
      echo_frame_r <= '0;
      miso_r       <= 1'b0;
    end else if ((state_r == LOAD) && !cs_rise_s) begin
      if (frame_end_s) begin
        echo_frame_r <= wr_data_s;
      end
      if (sck_fall_s) begin
        miso_r <= echo_frame_r[echo_idx_s];
      end
    end else begin
      miso_r <= 1'b0;
    end
  end

  assign spi_miso = miso_r;
`else
  logic sck_fall_unused_s;
  logic frame_end_unused_s;

  assign sck_fall_unused_s  = sck_fall_s;
  assign frame_end_unused_s = frame_end_s;
  assign spi_miso           = 1'b0;
`endif

endmodule

// File: tb/tb_spi_program_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_program_loader
// Self-checking bench for spi_program_loader (default parameters). A queue
// holds the program the loader should have stored; SPI frames, replay order,
// start pulse, overflow and echo expectations are derived from it.
// -----------------------------------------------------------------------------
module tb_spi_program_loader;

  localparam int HALF = 6;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       run = 1'b0;
  logic       spi_miso;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic       start;
  logic       busy;
  logic [5:0] prog_len;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] model_prog[$];
  logic        model_ovf = 1'b0;

  always #5 clk = ~clk;

  spi_program_loader dut (
    .clk      (clk),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .run      (run),
    .opcode   (opcode),
    .operand  (operand),
    .start    (start),
    .busy     (busy),
    .prog_len (prog_len),
    .overflow (overflow)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shift one frame MSB first; echo captures miso as the master would on each sck rise
  task automatic spi_frame(input logic [11:0] f, output logic [11:0] echo);
    for (int i = 11; i >= 0; i--) begin
      spi_mosi = f[i];
      tick(HALF);
      echo[i]  = spi_miso;
      spi_sck  = 1'b1;
      tick(HALF);
      spi_sck  = 1'b0;
    end
  endtask

  task automatic cs_open();
    spi_cs_n = 1'b0;
    model_prog.delete();
    model_ovf = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_close();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic model_store(input logic [11:0] f);
    if (model_prog.size() < 32) model_prog.push_back(f);
    else model_ovf = 1'b1;
  endtask

  task automatic load_frames(input logic [11:0] frames[$]);
    logic [11:0] echo;
    cs_open();
    foreach (frames[k]) begin
      spi_frame(frames[k], echo);
      model_store(frames[k]);
    end
    cs_close();
  endtask

  // Rising edge on run, then check every replayed instruction, the start pulse and return to idle.
  // With disturb set, SPI and run activity is injected while instructions are replayed.
  task automatic run_and_check(input string tag, input bit disturb);
    int len;
    len = model_prog.size();
    run = 1'b0;
    tick(2);
    run = 1'b1;
    tick(1);
    for (int i = 0; i < len; i++) begin
      n_cmp++;
      if ({opcode, operand} !== model_prog[i] || busy !== 1'b1 || start !== 1'b0) begin
        n_err++;
        $display("FAIL %s instr %0d: got op=%h opd=%h busy=%b start=%b, expected %h busy=1 start=0",
                 tag, i, opcode, operand, busy, start, model_prog[i]);
      end
      if (disturb) begin
        case (i)
          2:       spi_cs_n = 1'b0;
          4:       run = 1'b0;
          6:       run = 1'b1;
          8:       spi_sck = 1'b1;
          12:      spi_sck = 1'b0;
          16:      begin spi_mosi = 1'b1; spi_sck = 1'b1; end
          20:      spi_sck = 1'b0;
          default: ;
        endcase
      end
      tick(1);
    end
    n_cmp++;
    if (start !== 1'b1 || busy !== 1'b1 || opcode !== 4'h0 || operand !== 8'h00) begin
      n_err++;
      $display("FAIL %s finish: got start=%b busy=%b op=%h opd=%h, expected start=1 busy=1 op=0 opd=00",
               tag, start, busy, opcode, operand);
    end
    tick(1);
    n_cmp++;
    if (start !== 1'b0 || busy !== 1'b0 || opcode !== 4'h0 || operand !== 8'h00) begin
      n_err++;
      $display("FAIL %s idle: got start=%b busy=%b op=%h opd=%h, expected start=0 busy=0 op=0 opd=00",
               tag, start, busy, opcode, operand);
    end
    run = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    n_cmp++;
    if (opcode !== 4'h0 || operand !== 8'h00 || start !== 1'b0 || busy !== 1'b0 ||
        prog_len !== 6'd0 || overflow !== 1'b0 || spi_miso !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got op=%h opd=%h start=%b busy=%b len=%0d ovf=%b miso=%b, expected all zero",
               opcode, operand, start, busy, prog_len, overflow, spi_miso);
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_load_run();
    logic [11:0] fr[$];
    logic [11:0] echo;
    fr = '{12'h1A5, 12'h234, 12'hF00};
    cs_open();
    n_cmp++;
    if (busy !== 1'b1 || prog_len !== 6'd0) begin
      n_err++;
      $display("FAIL load_busy: got busy=%b len=%0d, expected busy=1 len=0", busy, prog_len);
    end
    foreach (fr[k]) begin
      spi_frame(fr[k], echo);
      model_store(fr[k]);
    end
    cs_close();
    n_cmp++;
    if (prog_len !== 6'd3 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL load3: got len=%0d ovf=%b busy=%b, expected len=3 ovf=0 busy=0", prog_len, overflow, busy);
    end
    run_and_check("run3", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      logic [11:0] fr[$];
      int n;
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) fr.push_back(12'($urandom));
      load_frames(fr);
      n_cmp++;
      if (prog_len !== 6'(model_prog.size()) || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL rand_len%0d: got len=%0d ovf=%b, expected len=%0d ovf=0",
                 it, prog_len, overflow, model_prog.size());
      end
      run_and_check("rand_run", 1'b0);
      // The buffer persists, so a second run replays the same program
      if (it == 1) run_and_check("rand_rerun", 1'b0);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] fr[$];
    for (int k = 0; k < 33; k++) fr.push_back(12'($urandom));
    load_frames(fr);
    n_cmp++;
    if (prog_len !== 6'd32 || overflow !== 1'b1 || model_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: got len=%0d ovf=%b, expected len=32 ovf=1", prog_len, overflow);
    end
    run_and_check("run32", 1'b0);
  endtask

  task automatic test_run_interference();
    logic [11:0] echo;
    // cs_n falls during RUN, sck toggles and run re-rises: replay must be unaffected
    run_and_check("run_disturb", 1'b1);
    // cs_n is still low; clocking a whole frame now must not load anything
    spi_frame(12'hABC, echo);
    n_cmp++;
    if (busy !== 1'b0 || prog_len !== 6'd32 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL no_load_after_run: got busy=%b len=%0d ovf=%b, expected busy=0 len=32 ovf=1",
               busy, prog_len, overflow);
    end
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(8);
    run_and_check("run_after_disturb", 1'b0);
  endtask

  task automatic test_partial();
    cs_open();
    for (int i = 0; i < 7; i++) begin
      spi_mosi = 1'($urandom);
      tick(HALF);
      spi_sck = 1'b1;
      tick(HALF);
      spi_sck = 1'b0;
    end
    cs_close();
    n_cmp++;
    if (prog_len !== 6'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL partial: got len=%0d ovf=%b busy=%b, expected len=0 ovf=0 busy=0", prog_len, overflow, busy);
    end
    run_and_check("run_empty", 1'b0);
  endtask

  task automatic test_echo();
    logic [11:0] e1, e2, x1, x2;
`ifdef SPI_LOADER_ECHO_EN
    x1 = 12'h000;
    x2 = 12'h1A5;
`else
    x1 = 12'h000;
    x2 = 12'h000;
`endif
    cs_open();
    spi_frame(12'h1A5, e1);
    model_store(12'h1A5);
    spi_frame(12'h3C3, e2);
    model_store(12'h3C3);
    cs_close();
    n_cmp++;
    if (e1 !== x1 || e2 !== x2) begin
      n_err++;
      $display("FAIL echo: got %h,%h expected %h,%h", e1, e2, x1, x2);
    end
    n_cmp++;
    if (spi_miso !== 1'b0 || prog_len !== 6'd2) begin
      n_err++;
      $display("FAIL echo_idle: got miso=%b len=%0d, expected miso=0 len=2", spi_miso, prog_len);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    seen = 1'b0;
    run = 1'b0;
    tick(2);
    run = 1'b1;
    tick(1);
    n_cmp++;
    if ({opcode, operand} !== model_prog[0]) begin
      n_err++;
      $display("FAIL rst_run_first: got %h%h expected %h", opcode, operand, model_prog[0]);
    end
    reset = 1'b0;
    run = 1'b0;
    tick(1);
    n_cmp++;
    if (opcode !== 4'h0 || operand !== 8'h00 || start !== 1'b0 || busy !== 1'b0 ||
        prog_len !== 6'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rst_run: got op=%h opd=%h start=%b busy=%b len=%0d ovf=%b, expected reset values",
               opcode, operand, start, busy, prog_len, overflow);
    end
    reset = 1'b1;
    model_prog.delete();
    model_ovf = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (start === 1'b1) seen = 1'b1;
      tick(1);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_start: got start pulse=%b expected 0", seen);
    end
    run_and_check("run_after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_random();
    test_overflow();
    test_run_interference();
    test_partial();
    test_echo();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
